// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, command bytes and the device ACK code.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 line, plus a falling-edge strobe on the synced level.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    // Lines idle high (pulled up), so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            meta_reg <= line_in;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign level = sync_reg;
    assign fall  = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (inhibit, request-to-send, 11-bit frame, ACK check).
// Define PS2_TX_TIMEOUT_EN to add a frame watchdog that aborts with tx_err.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6500,
    parameter int TIMEOUT_CYCLES = 1300000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

    ps2_tx_state_t    state_reg;
    ps2_tx_state_t    state_next;
    logic [INH_W-1:0] inh_cnt_reg;
    logic [3:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic             parity_reg;
    logic             data_oe_reg;
    logic             tx_done_reg;
    logic             tx_err_reg;
    logic             done_next;
    logic             err_next;
    logic             timeout;

    logic [1:0] line_raw;
    logic [1:0] line_level;
    logic [1:0] line_fall;
    logic       clk_fall;
    logic       clk_level;
    logic       data_level;
    logic       unused_data_fall;

    // Index 0 is the clock line, index 1 the data line.
    assign line_raw = {ps2_data_in, ps2_clk_in};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        ps2_line_sync u_sync (
            .clk     (clk),
            .rst     (rst),
            .line_in (line_raw[gi]),
            .level   (line_level[gi]),
            .fall    (line_fall[gi])
        );
    end

    assign clk_fall         = line_fall[0];
    assign clk_level        = line_level[0];
    assign data_level       = line_level[1];
    assign unused_data_fall = line_fall[1];

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_reg;
    logic            in_frame;

    assign in_frame = (state_reg == SHIFT) || (state_reg == ACK) || (state_reg == WAIT_IDLE);
    assign timeout  = in_frame && (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

    // Runs only while the device owns the clock; any return to IDLE restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_reg <= '0;
        end else if (in_frame && state_next != IDLE) begin
            wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
        end else begin
            wd_cnt_reg <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (tx_start) begin
                    state_next = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_reg == INH_W'(INHIBIT_CYCLES - 1)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                state_next = SHIFT;
            end
            SHIFT: begin
                if (clk_fall && bit_cnt_reg == 4'd9) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    if (data_level) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_level && data_level) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (timeout) begin
            state_next = IDLE;
            done_next  = 1'b0;
            err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inh_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            data_oe_reg <= 1'b0;
            tx_done_reg <= 1'b0;
            tx_err_reg  <= 1'b0;
        end else begin
            tx_done_reg <= done_next;
            tx_err_reg  <= err_next;
            case (state_reg)
                IDLE: begin
                    inh_cnt_reg <= '0;
                    if (tx_start) begin
                        shift_reg  <= tx_data;
                        parity_reg <= ~^tx_data;
                    end
                end
                INHIBIT: begin
                    inh_cnt_reg <= inh_cnt_reg + INH_W'(1);
                end
                REQ: begin
                    data_oe_reg <= 1'b1;
                end
                SHIFT: begin
                    // Each device falling edge presents the next bit; the device samples on the rise.
                    if (clk_fall) begin
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg < 4'd8) begin
                            data_oe_reg <= ~shift_reg[0];
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                        end else if (bit_cnt_reg == 4'd8) begin
                            data_oe_reg <= ~parity_reg;
                        end else begin
                            data_oe_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
            if (state_next == IDLE) begin
                bit_cnt_reg <= '0;
                data_oe_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        busy        = (state_reg != IDLE);
        ps2_clk_oe  = (state_reg == INHIBIT) || (state_reg == REQ);
        ps2_data_oe = (state_reg == REQ) || ((state_reg == SHIFT) && data_oe_reg);
        tx_done     = tx_done_reg;
        tx_err      = tx_err_reg;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model (honours PS2_TX_TIMEOUT_EN).
module tb_ps2_host_tx;

    localparam int INH  = 6500;
    localparam int TO   = 3000;
    localparam int HALF = 25;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_line;
    logic       ps2_data_line;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
    end

    task automatic start_frame(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Counts inhibit and request cycles; returns on the first cycle with the clock released.
    task automatic wait_req(output int inh, output int req, output bit ok);
        inh = 0;
        req = 0;
        ok  = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (ps2_clk_oe && !ps2_data_oe) inh++;
            else if (ps2_clk_oe && ps2_data_oe) req++;
            else if (req > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic dev_frame(input bit ack, input int start_edge, input int rst_edge,
                             output logic [9:0] bits);
        bits = '0;
        for (int e = 1; e <= 11; e++) begin
            if (e == 11 && ack) dev_data = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            if (e == start_edge) begin
                tx_data  = 8'h00;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
            if (e == rst_edge) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                dev_clk = 1'b1;
                return;
            end
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (e <= 10) bits[e-1] = ps2_data_line;
            if (e == 11) dev_data = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_in: outputs got %b required 00000",
                     {busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_after: outputs got %b required 00000",
                     {busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err});
        end
    endtask

    task automatic test_set_led();
        int inh, req, d0, e0;
        bit ok;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        start_frame(8'hED);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL led_busy_start: busy got %b required 1", busy);
        end
        wait_req(inh, req, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL led_req_timeout: request sequence not seen");
        end
        checks++;
        if (inh != INH) begin
            failures++;
            $display("FAIL led_inhibit: clk_oe-only cycles got %0d required %0d", inh, INH);
        end
        checks++;
        if (req != 1) begin
            failures++;
            $display("FAIL led_req: request cycles got %0d required 1", req);
        end
        dev_frame(1'b1, 0, 0, bits);
        checks++;
        if (bits !== 10'h3ED) begin
            failures++;
            $display("FAIL led_bits: {stop,par,D7..D0} got %h required 3ed", bits);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            failures++;
            $display("FAIL led_pulses: done=%0d err=%0d required done=1 err=0",
                     done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if ({busy, ps2_clk_oe, ps2_data_oe} !== 3'b000) begin
            failures++;
            $display("FAIL led_idle: busy/clk_oe/data_oe got %b required 000",
                     {busy, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_no_ack();
        int inh, req, d0, e0;
        bit ok;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        start_frame(8'hF4);
        wait_req(inh, req, ok);
        dev_frame(1'b0, 0, 0, bits);
        checks++;
        if (bits !== 10'h2F4) begin
            failures++;
            $display("FAIL noack_bits: got %h required 2f4", bits);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            failures++;
            $display("FAIL noack_pulses: err=%0d done=%0d required err=1 done=0",
                     err_cnt - e0, done_cnt - d0);
        end
        checks++;
        if ({busy, ps2_clk_oe, ps2_data_oe} !== 3'b000) begin
            failures++;
            $display("FAIL noack_idle: busy/clk_oe/data_oe got %b required 000",
                     {busy, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_parity();
        int inh, req;
        bit ok;
        logic [9:0] bits;
        start_frame(8'h00);
        wait_req(inh, req, ok);
        dev_frame(1'b1, 0, 0, bits);
        checks++;
        if (bits !== 10'h300) begin
            failures++;
            $display("FAIL parity_00: got %h required 300", bits);
        end
        repeat (20) @(negedge clk);
        start_frame(8'h01);
        wait_req(inh, req, ok);
        dev_frame(1'b1, 0, 0, bits);
        checks++;
        if (bits !== 10'h201) begin
            failures++;
            $display("FAIL parity_01: got %h required 201", bits);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int inh, req, d0;
        bit ok;
        logic [9:0] bits;
        d0 = done_cnt;
        start_frame(8'hFF);
        wait_req(inh, req, ok);
        dev_frame(1'b1, 4, 0, bits);
        checks++;
        if (bits !== 10'h3FF) begin
            failures++;
            $display("FAIL busy_start_bits: got %h required 3ff", bits);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_done: done=%0d busy=%b required done=1 busy=0",
                     done_cnt - d0, busy);
        end
    endtask

    task automatic test_mid_reset();
        int inh, req, d0, e0;
        bit ok;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        start_frame(8'hFF);
        wait_req(inh, req, ok);
        dev_frame(1'b1, 0, 6, bits);
        checks++;
        if ({busy, ps2_clk_oe, ps2_data_oe} !== 3'b000) begin
            failures++;
            $display("FAIL rst_release: busy/clk_oe/data_oe got %b required 000",
                     {busy, ps2_clk_oe, ps2_data_oe});
        end
        repeat (50) @(negedge clk);
        checks++;
        if (done_cnt != d0 || err_cnt != e0) begin
            failures++;
            $display("FAIL rst_pulses: done=%0d err=%0d required 0 0",
                     done_cnt - d0, err_cnt - e0);
        end
        start_frame(8'hF4);
        wait_req(inh, req, ok);
        dev_frame(1'b1, 0, 0, bits);
        checks++;
        if (bits !== 10'h2F4) begin
            failures++;
            $display("FAIL rst_next_bits: got %h required 2f4", bits);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            failures++;
            $display("FAIL rst_next_done: done=%0d err=%0d required 1 0",
                     done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_timeout();
        int inh, req, n;
        bit ok;
        start_frame(8'hF4);
        wait_req(inh, req, ok);
`ifdef PS2_TX_TIMEOUT_EN
        n = 0;
        while (!tx_err && n < 2 * TO) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != TO) begin
            failures++;
            $display("FAIL timeout_cycles: tx_err after %0d cycles required %0d", n, TO);
        end
        checks++;
        if ({busy, ps2_clk_oe, ps2_data_oe} !== 3'b000) begin
            failures++;
            $display("FAIL timeout_idle: busy/clk_oe/data_oe got %b required 000",
                     {busy, ps2_clk_oe, ps2_data_oe});
        end
`else
        n = 0;
        repeat (2 * TO) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ps2_clk_oe !== 1'b0) begin
            failures++;
            $display("FAIL no_watchdog_busy: busy=%b clk_oe=%b required 1 0", busy, ps2_clk_oe);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL no_watchdog_rst: busy got %b required 0", busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_set_led();
        test_no_ack();
        test_parity();
        test_start_while_busy();
        test_mid_reset();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
